// File: rtl/led_fade_pwm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_fade_pwm : per-LED brightness ramp rendered through a shared PWM     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module led_fade_pwm #(
    parameter int CHANNELS   = 5,
    parameter int PWM_BITS   = 8,
    parameter int FADE_DIV   = 12_000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] LED_REQ,
    output logic [CHANNELS-1:0] LED_OUT,
    output logic                BUSY
);

    localparam int                  PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic                INV      = (ACTIVE_LOW != 0);

    logic [CHANNELS-1:0] req_q, req_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] level_q [CHANNELS];
    logic [PWM_BITS-1:0] level_d [CHANNELS];
    logic [PWM_BITS-1:0] duty_q  [CHANNELS];
    logic [PWM_BITS-1:0] duty_d  [CHANNELS];
    logic [CHANNELS-1:0] led_out_q, led_out_d;
    logic                busy_q, busy_d;
    logic                tick;
    logic                pwm_last;

    always_comb begin
        tick      = (pre_q == PRE_LAST);
        pwm_last  = (pwm_cnt_q == PWM_LAST);
        req_d     = LED_REQ;
        pre_d     = tick ? '0 : pre_q + PRE_W'(1);
        pwm_cnt_d = pwm_last ? '0 : pwm_cnt_q + PWM_BITS'(1);
        busy_d    = 1'b0;
        led_out_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level_d[i] = level_q[i];
            // Duty only moves at a period boundary so a period is never split.
            duty_d[i]    = pwm_last ? level_q[i] : duty_q[i];
            led_out_d[i] = (pwm_cnt_q < duty_q[i]) ^ INV;
            if (level_q[i] != (req_q[i] ? MAX : '0)) begin
                busy_d = 1'b1;
            end
            if (tick) begin
                if (req_q[i] && (level_q[i] != MAX)) begin
                    level_d[i] = level_q[i] + PWM_BITS'(1);
                end else if (!req_q[i] && (level_q[i] != '0)) begin
                    level_d[i] = level_q[i] - PWM_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q     <= '0;
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            led_out_q <= {CHANNELS{INV}};
            busy_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= '0;
                duty_q[i]  <= '0;
            end
        end else begin
            req_q     <= req_d;
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            for (int i = 0; i < CHANNELS; i++) begin
                level_q[i] <= level_d[i];
                duty_q[i]  <= duty_d[i];
            end
        end
    end

    assign LED_OUT = led_out_q;
    assign BUSY    = busy_q;

endmodule
`default_nettype wire

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
Downstream stage of the LED sequencer. It consumes the sequencer's 5-bit per-LED on/off request vector and drives the physical iCEstick LED pins. Each LED fades smoothly between off and full brightness instead of switching hard. Each channel has its own brightness level, which ramps one step per fade tick and is rendered through a shared PWM counter.

Parameters:
CHANNELS, 5, number of LED channels.
PWM_BITS, 8, width of the PWM counter and brightness level. MAX = 2^PWM_BITS-1. Legal range 2..16.
FADE_DIV, 12_000, CLK cycles per fade tick (1 ms at 12 MHz, so a full fade takes 255 ms). Must be >= 1.
ACTIVE_LOW, 0, when 1, LED_OUT is inverted (lit = 0).

Ports:
CLK  in  1  12 MHz system clock.
RST_N  in  1  reset; asynchronous, active-low.
LED_REQ  in  CHANNELS  target per LED: 1 = ramp to full, 0 = ramp to off. Synchronous to CLK.
LED_OUT  out  CHANNELS  PWM drive to the LED pins, registered.
BUSY  out  1  1 while any channel's level differs from its target.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately even mid-ramp):
  - req_q, prescaler, pwm_cnt, level[], duty[] and BUSY are all 0.
  - LED_OUT = {CHANNELS{ACTIVE_LOW}}.
- req_q <= LED_REQ every cycle. This is 1 cycle of input latency; all decisions use req_q.
- Prescaler:
  - Counts 0..FADE_DIV-1 and wraps to 0.
  - tick = (prescaler == FADE_DIV-1). With FADE_DIV=1, tick is asserted every cycle.
  - The first tick occurs FADE_DIV cycles after reset release.
- Level update, on tick, per channel i:
  - req_q[i]=1 and level[i]<MAX: level[i] +1.
  - req_q[i]=0 and level[i]>0: level[i] -1.
  - Otherwise hold. Levels saturate at 0 and MAX and never wrap.
- Direction reversal mid-ramp: the new direction applies at the next tick. The level is never reset and never jumps.
- PWM counter: pwm_cnt counts 0..MAX-1 and wraps to 0, giving a period of MAX cycles.
- Glitch-free shadowing:
  - duty[i] <= level[i] only in the cycle where pwm_cnt == MAX-1.
  - A level change is therefore visible from the start of the next PWM period, never mid-period.
- Output: LED_OUT[i] <= (pwm_cnt < duty[i]) XOR ACTIVE_LOW.
  - duty = 0: never lit.
  - duty = MAX: lit for the whole period, no single-cycle dropout.
  - duty = k: exactly k lit cycles per MAX-cycle period.
- BUSY <= OR over i of (level[i] != (req_q[i] ? MAX : 0)).
  - Registered, so it lags level by 1 cycle.
- Simultaneous events:
  - A tick coinciding with pwm_cnt == MAX-1: duty captures the pre-tick level. The new level shows one period later.
  - An LED_REQ change in the same cycle as a tick: the tick uses the old req_q.
- Channels are fully independent. Any request pattern is legal (one-hot, all-on, all-off).
- Widths:
  - prescaler width = clog2(FADE_DIV), minimum 1.
  - pwm_cnt, level and duty are PWM_BITS wide.
  - No arithmetic overflow is possible given the saturation above.

Test Plan:
(all with PWM_BITS=4 (MAX=15), FADE_DIV=4, CHANNELS=5, ACTIVE_LOW=0 unless stated)
1. Reset and idle: hold RST_N low, then release with LED_REQ=0 -> LED_OUT=00000 and BUSY=0 for 200 cycles.
2. Fade up: LED_REQ=00001 held -> BUSY rises; level[0] reaches 15 after 15 ticks (~61 cycles); BUSY falls. Each PWM period, count LED_OUT[0] high cycles: they equal the period's duty, monotonically non-decreasing, ending at 15/15 (constant 1). LED_OUT[4:1] stay 0.
3. Fade down: from full, set LED_REQ=00000 -> level[0] decreases by 1 per tick to 0 in 15 ticks. LED_OUT[0] is then 0 permanently and BUSY=0.
4. Reversal: LED_REQ=00100 for 8 ticks, then 00000 -> level[2] peaks at 8, returns to 0 after 8 further ticks, with no step larger than 1.
5. Async reset mid-ramp: pulse RST_N low between clock edges while LED_REQ=11111 and levels are ~7 -> LED_OUT=00000 before the next edge. After release, ramping restarts from 0.
6. Inversion and extremes: ACTIVE_LOW=1, FADE_DIV=1, LED_REQ=11111 -> at reset LED_OUT=11111. After 15 cycles plus one PWM period, LED_OUT=00000 constantly (full on, active low).
